// File: rtl/fc_pkg.sv
// Fast-command shared definitions: code words, request bit indices and the
// 4-bit decode values used when cross-checking against the decoder.
package fc_pkg;

    // 8-bit Hamming code words carried in each 40 MHz frame
    localparam logic [7:0] CODE_IDLE       = 8'hF0;
    localparam logic [7:0] CODE_LINK_RESET = 8'h33;
    localparam logic [7:0] CODE_BCR        = 8'h5A;
    localparam logic [7:0] CODE_SYNC_TRIG  = 8'h55;
    localparam logic [7:0] CODE_L1A_CR     = 8'h66;
    localparam logic [7:0] CODE_CHARGE_INJ = 8'h69;
    localparam logic [7:0] CODE_L1A        = 8'h96;
    localparam logic [7:0] CODE_L1A_BCR    = 8'h99;
    localparam logic [7:0] CODE_WS_START   = 8'hA5;
    localparam logic [7:0] CODE_WS_STOP    = 8'hAA;

    // Bit positions in the request vector
    localparam int unsigned REQ_LINK_RESET = 0;
    localparam int unsigned REQ_BCR        = 1;
    localparam int unsigned REQ_SYNC_TRIG  = 2;
    localparam int unsigned REQ_L1A_CR     = 3;
    localparam int unsigned REQ_CHARGE_INJ = 4;
    localparam int unsigned REQ_L1A        = 5;
    localparam int unsigned REQ_WS_START   = 6;
    localparam int unsigned REQ_WS_STOP    = 7;

    // Decoder-side command identifiers
    typedef enum logic [3:0] {
        CMD_IDLE       = 4'h0,
        CMD_LINK_RESET = 4'h1,
        CMD_BCR        = 4'h2,
        CMD_SYNC_TRIG  = 4'h3,
        CMD_L1A_CR     = 4'h4,
        CMD_CHARGE_INJ = 4'h5,
        CMD_L1A        = 4'h6,
        CMD_L1A_BCR    = 4'h7,
        CMD_WS_START   = 4'h8,
        CMD_WS_STOP    = 4'h9
    } fcCmd_e;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } schedState_e;

    // Map a command identifier to its on-line code word
    function automatic logic [7:0] cmdCode(input fcCmd_e cmd);
        case (cmd)
            CMD_LINK_RESET: return CODE_LINK_RESET;
            CMD_BCR:        return CODE_BCR;
            CMD_SYNC_TRIG:  return CODE_SYNC_TRIG;
            CMD_L1A_CR:     return CODE_L1A_CR;
            CMD_CHARGE_INJ: return CODE_CHARGE_INJ;
            CMD_L1A:        return CODE_L1A;
            CMD_L1A_BCR:    return CODE_L1A_BCR;
            CMD_WS_START:   return CODE_WS_START;
            CMD_WS_STOP:    return CODE_WS_STOP;
            default:        return CODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fc_scheduler_if.sv
// Request/status bundle between a command source and the fast-command scheduler.
interface fc_scheduler_if;
    logic [7:0] req;
    logic       clr_err;
    logic       fc;
    logic       frame_start;
    logic [7:0] sent;
    logic       align_done;
    logic [7:0] drop_err;

    modport master (
        output req, clr_err,
        input  fc, frame_start, sent, align_done, drop_err
    );

    modport slave (
        input  req, clr_err,
        output fc, frame_start, sent, align_done, drop_err
    );
endinterface

// File: rtl/fc_prio_sel.sv
// Combinational priority selector with L1A/BCR merge: picks the code word for
// the next frame and the mask of requests that frame consumes.
module fc_prio_sel
    import fc_pkg::*;
(
    input  logic [7:0] eligible,
    output logic [7:0] code,
    output logic [7:0] clrMask
);

    fcCmd_e cmd;

    // Fixed-priority pick; L1A+BCR together collapse into one merged word
    always_comb begin
        cmd     = CMD_IDLE;
        clrMask = '0;
        if (eligible[REQ_LINK_RESET]) begin
            cmd                     = CMD_LINK_RESET;
            clrMask[REQ_LINK_RESET] = 1'b1;
        end else if (eligible[REQ_L1A] && eligible[REQ_BCR]) begin
            cmd              = CMD_L1A_BCR;
            clrMask[REQ_L1A] = 1'b1;
            clrMask[REQ_BCR] = 1'b1;
        end else if (eligible[REQ_L1A]) begin
            cmd              = CMD_L1A;
            clrMask[REQ_L1A] = 1'b1;
        end else if (eligible[REQ_BCR]) begin
            cmd              = CMD_BCR;
            clrMask[REQ_BCR] = 1'b1;
        end else if (eligible[REQ_L1A_CR]) begin
            cmd                 = CMD_L1A_CR;
            clrMask[REQ_L1A_CR] = 1'b1;
        end else if (eligible[REQ_CHARGE_INJ]) begin
            cmd                     = CMD_CHARGE_INJ;
            clrMask[REQ_CHARGE_INJ] = 1'b1;
        end else if (eligible[REQ_SYNC_TRIG]) begin
            cmd                    = CMD_SYNC_TRIG;
            clrMask[REQ_SYNC_TRIG] = 1'b1;
        end else if (eligible[REQ_WS_START]) begin
            cmd                   = CMD_WS_START;
            clrMask[REQ_WS_START] = 1'b1;
        end else if (eligible[REQ_WS_STOP]) begin
            cmd                  = CMD_WS_STOP;
            clrMask[REQ_WS_STOP] = 1'b1;
        end
        code = cmdCode(cmd);
    end

endmodule

// File: rtl/fc_scheduler.sv
// Transmit-side fast-command scheduler: serialises one 8-bit code word per
// 40 MHz frame, MSB first, on the 320 MHz line after an IDLE preamble.
// Optional feature macro: FC_PERIODIC_BCR_EN (internal per-orbit BCR).
module fc_scheduler
    import fc_pkg::*;
#(
    parameter int unsigned INIT_IDLE = 16,
    parameter int unsigned ORBIT_LEN = 3564
) (
    input  logic           clk320_aligned,
    input  logic           rst,
    fc_scheduler_if.slave  bus
);

    localparam int unsigned INIT_W = $clog2(INIT_IDLE + 1);

    schedState_e       state;
    schedState_e       stateNext;
    logic [2:0]        cnt;
    logic [7:0]        sh;
    logic [7:0]        pend;
    logic [7:0]        sentQ;
    logic [7:0]        dropErr;
    logic              alignDone;
    logic [INIT_W-1:0] initCnt;

    logic              frameEnd;
    logic              loadRun;
    logic              intBcr;
    logic [7:0]        reqEff;
    logic [7:0]        eligible;
    logic [7:0]        selCode;
    logic [7:0]        selClr;
    logic [7:0]        loadClr;
    logic [7:0]        drop;

    assign frameEnd = (cnt == 3'd7);
    assign loadRun  = frameEnd && (state == ST_RUN);

`ifdef FC_PERIODIC_BCR_EN
    localparam int unsigned ORBIT_W = $clog2(ORBIT_LEN + 1);

    logic [ORBIT_W-1:0] orbitCnt;

    // Orbit frame counter, advancing once per RUN frame selection
    always_ff @(posedge clk320_aligned) begin
        if (rst) begin
            orbitCnt <= '0;
        end else if (loadRun) begin
            if (orbitCnt == ORBIT_W'(ORBIT_LEN - 1)) begin
                orbitCnt <= '0;
            end else begin
                orbitCnt <= orbitCnt + ORBIT_W'(1);
            end
        end
    end

    assign intBcr = loadRun && (orbitCnt == '0);
`else
    logic unusedOrbitLen;
    assign unusedOrbitLen = ^ORBIT_LEN;
    assign intBcr         = 1'b0;
`endif

    // Internal BCR feeds eligibility and pending, but never the drop detector
    assign reqEff   = bus.req | {6'b0, intBcr, 1'b0};
    assign eligible = pend | reqEff;
    assign loadClr  = loadRun ? selClr : '0;
    assign drop     = bus.req & pend & ~loadClr;

    fc_prio_sel u_prioSel (
        .eligible (eligible),
        .code     (selCode),
        .clrMask  (selClr)
    );

    // State register
    always_ff @(posedge clk320_aligned) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: leave INIT at the end of the last preamble frame
    always_comb begin
        stateNext = state;
        case (state)
            ST_INIT: begin
                if (frameEnd && (initCnt == INIT_W'(INIT_IDLE - 1))) begin
                    stateNext = ST_RUN;
                end
            end
            ST_RUN:  stateNext = ST_RUN;
            default: stateNext = ST_INIT;
        endcase
    end

    // Preamble frame counter
    always_ff @(posedge clk320_aligned) begin
        if (rst) begin
            initCnt <= '0;
        end else if ((state == ST_INIT) && frameEnd) begin
            initCnt <= initCnt + INIT_W'(1);
        end
    end

    // Frame engine: bit counter and MSB-first shift register
    always_ff @(posedge clk320_aligned) begin
        if (rst) begin
            cnt <= '0;
            sh  <= CODE_IDLE;
        end else begin
            cnt <= cnt + 3'd1;
            if (frameEnd) begin
                sh <= loadRun ? selCode : CODE_IDLE;
            end else begin
                sh <= {sh[6:0], 1'b0};
            end
        end
    end

    // Pending flags, sent pulse, alignment flag and sticky drop flags
    always_ff @(posedge clk320_aligned) begin
        if (rst) begin
            pend      <= '0;
            sentQ     <= '0;
            alignDone <= 1'b0;
            dropErr   <= '0;
        end else begin
            pend      <= (pend | reqEff) & ~loadClr;
            sentQ     <= loadClr;
            alignDone <= (stateNext == ST_RUN);
            dropErr   <= (bus.clr_err ? 8'h00 : dropErr) | drop;
        end
    end

    assign bus.fc         = sh[7];
    // Decoded from the registered bit counter so the first cycle after reset
    // release is already marked as a frame start
    assign bus.frame_start = (cnt == 3'd0) && !rst;
    assign bus.sent        = sentQ;
    assign bus.align_done  = alignDone;
    assign bus.drop_err    = dropErr;

endmodule

// File: tb/tb_fc_scheduler.sv
// Directed self-checking bench for fc_scheduler.
// With FC_PERIODIC_BCR_EN defined it checks the periodic BCR with ORBIT_LEN=4.
module tb_fc_scheduler;
    import fc_pkg::*;

`ifdef FC_PERIODIC_BCR_EN
    localparam int unsigned ORBIT_LEN_TB = 4;
`else
    localparam int unsigned ORBIT_LEN_TB = 3564;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    fc_scheduler_if bus ();

    fc_scheduler #(
        .INIT_IDLE (16),
        .ORBIT_LEN (ORBIT_LEN_TB)
    ) dut (
        .clk320_aligned (clk),
        .rst            (rst),
        .bus            (bus)
    );

    always #2 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold reset for a few edges, check reset values, release into cycle 0
    task automatic doReset();
        rst         = 1'b1;
        bus.req     = '0;
        bus.clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fc", 8'(bus.fc), 8'h01);
        check("rst_frame_start", 8'(bus.frame_start), 8'h00);
        check("rst_sent", bus.sent, 8'h00);
        check("rst_align", 8'(bus.align_done), 8'h00);
        check("rst_drop", bus.drop_err, 8'h00);
        rst = 1'b0;
        cyc = 0;
    endtask

    // One 8-cycle frame: optional two request pulses and a clr_err pulse at
    // the given offsets, then check the captured word and status outputs
    task automatic frame(input int fr, input logic [7:0] rA, input int oA,
                         input logic [7:0] rB, input int oB, input int clrOff,
                         input logic [7:0] expWord, input logic [7:0] expSent,
                         input logic expAlign, input logic [7:0] expDrop);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            bus.req     = ((i == oA) ? rA : 8'h00) | ((i == oB) ? rB : 8'h00);
            bus.clr_err = (i == clrOff);
            @(negedge clk);
            w = {w[6:0], bus.fc};
            if (i == 0) begin
                check($sformatf("f%0d_frame_start", fr), 8'(bus.frame_start), 8'h01);
                check($sformatf("f%0d_sent", fr), bus.sent, expSent);
                check($sformatf("f%0d_align0", fr), 8'(bus.align_done), 8'(expAlign));
            end
            if (i == 4) begin
                check($sformatf("f%0d_frame_start_mid", fr), 8'(bus.frame_start), 8'h00);
                check($sformatf("f%0d_sent_mid", fr), bus.sent, 8'h00);
            end
            if (i == 7) begin
                check($sformatf("f%0d_align7", fr), 8'(bus.align_done), 8'(expAlign));
                check($sformatf("f%0d_drop", fr), bus.drop_err, expDrop);
            end
            tick();
        end
        bus.req     = '0;
        bus.clr_err = 1'b0;
        check($sformatf("f%0d_word", fr), w, expWord);
    endtask

    task automatic preamble();
        for (int fr = 0; fr <= 16; fr++) begin
            frame(fr, 8'h00, -1, 8'h00, -1, -1, CODE_IDLE, 8'h00, (fr >= 16), 8'h00);
        end
    endtask

    initial begin
        bus.req     = '0;
        bus.clr_err = 1'b0;
        doReset();
        preamble();
`ifdef FC_PERIODIC_BCR_EN
        frame(17, 8'h00, -1, 8'h00, -1, -1, 8'h5A, 8'h02, 1'b1, 8'h00);
        frame(18, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(19, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        // External BCR in the same selection cycle as the internal one
        frame(20, 8'h02,  7, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(21, 8'h00, -1, 8'h00, -1, -1, 8'h5A, 8'h02, 1'b1, 8'h00);
        frame(22, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(23, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(24, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(25, 8'h00, -1, 8'h00, -1, -1, 8'h5A, 8'h02, 1'b1, 8'h00);
        frame(26, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
`else
        // L1A pulse at cycle 140
        frame(17, 8'h20,  4, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(18, 8'h00, -1, 8'h00, -1, -1, 8'h96, 8'h20, 1'b1, 8'h00);
        // L1A and BCR together
        frame(19, 8'h22,  2, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(20, 8'h00, -1, 8'h00, -1, -1, 8'h99, 8'h22, 1'b1, 8'h00);
        frame(21, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        // All eight in the selection cycle itself
        frame(22, 8'hFF,  7, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(23, 8'h00, -1, 8'h00, -1, -1, 8'h33, 8'h01, 1'b1, 8'h00);
        frame(24, 8'h00, -1, 8'h00, -1, -1, 8'h99, 8'h22, 1'b1, 8'h00);
        frame(25, 8'h00, -1, 8'h00, -1, -1, 8'h66, 8'h08, 1'b1, 8'h00);
        frame(26, 8'h00, -1, 8'h00, -1, -1, 8'h69, 8'h10, 1'b1, 8'h00);
        frame(27, 8'h00, -1, 8'h00, -1, -1, 8'h55, 8'h04, 1'b1, 8'h00);
        frame(28, 8'h00, -1, 8'h00, -1, -1, 8'hA5, 8'h40, 1'b1, 8'h00);
        frame(29, 8'h00, -1, 8'h00, -1, -1, 8'hAA, 8'h80, 1'b1, 8'h00);
        frame(30, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        // Two ChargeInj pulses two cycles apart: one send, drop flagged
        frame(31, 8'h10,  1, 8'h10,  3, -1, 8'hF0, 8'h00, 1'b1, 8'h10);
        frame(32, 8'h00, -1, 8'h00, -1, -1, 8'h69, 8'h10, 1'b1, 8'h10);
        frame(33, 8'h00, -1, 8'h00, -1,  0, 8'hF0, 8'h00, 1'b1, 8'h00);
        // Drop coinciding with clr_err keeps the flag set
        frame(34, 8'h10,  1, 8'h10,  4,  4, 8'hF0, 8'h00, 1'b1, 8'h10);
        frame(35, 8'h00, -1, 8'h00, -1, -1, 8'h69, 8'h10, 1'b1, 8'h10);
        // Repeat request in the very cycle it is loaded: merged, no drop
        frame(36, 8'h20,  1, 8'h20,  7,  0, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(37, 8'h00, -1, 8'h00, -1, -1, 8'h96, 8'h20, 1'b1, 8'h00);
        frame(38, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);

        // Reset at cycle 141 while an L1A is pending
        doReset();
        preamble();
        for (int i = 0; i < 6; i++) begin
            bus.req = (i == 4) ? 8'h20 : 8'h00;
            if (i == 5) rst = 1'b1;
            @(negedge clk);
            if (i == 5) check("pre_rst_fc", 8'(bus.fc), 8'h00);
            tick();
        end
        bus.req = '0;
        check("post_rst_fc", 8'(bus.fc), 8'h01);
        check("post_rst_align", 8'(bus.align_done), 8'h00);
        rst = 1'b0;
        cyc = 0;
        preamble();
        frame(17, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
        frame(18, 8'h00, -1, 8'h00, -1, -1, 8'hF0, 8'h00, 1'b1, 8'h00);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
